// File: rtl/ram_sp_18_stream_reader.sv
// Burst reader for the 1024x18 single-port RAM wrapper: streams `length` words from `start_addr`.
// Define RAM_SP_RD_WRAP_EN to let bursts wrap 1023 -> 0; otherwise out-of-range starts raise err.
module ram_sp_18_stream_reader #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              inflight_q;
  logic [1:0]        fill_q, fill_d;
  logic [DATA_W-1:0] buf_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pop, push, issue, range_bad;

`ifdef RAM_SP_RD_WRAP_EN
  assign range_bad = length > DEPTH;
`else
  logic [ADDR_W+1:0] range_end;
  assign range_end = {1'b0, length} + {2'b00, start_addr};
  assign range_bad = range_end > {1'b0, DEPTH};
`endif

  assign pop  = m_valid & m_ready;
  assign push = inflight_q;
  // Credit: occupancy after this edge plus the new read must fit in the two slots.
  assign issue = (state_q == READ) && (cnt_q != len_q) &&
                 (({1'b0, fill_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    ram_addr_d  = ram_addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fill_d      = fill_q + {1'b0, push} - {1'b0, pop};
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else if (range_bad) begin
            err_d = 1'b1;
          end else begin
            next_addr_d = start_addr;
            len_d       = length;
            cnt_d       = '0;
            state_d     = READ;
          end
        end
      end
      READ: begin
        if (issue) begin
          ram_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          cnt_d       = cnt_q + (ADDR_W + 1)'(1);
          if (cnt_d == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish on the edge that empties the buffer so done follows the last transfer.
        if (!inflight_q && (fill_q == {1'b0, pop})) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      ram_addr_q  <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      fill_q      <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      ram_addr_q  <= ram_addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      inflight_q  <= issue;
      fill_q      <= fill_d;
      done_q      <= done_d;
      err_q       <= err_d;
      if (push) begin
        buf_q[wr_ptr_q] <= ram_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign ram_addr = ram_addr_q;
  assign ram_we   = 1'b0;
  assign m_data   = buf_q[rd_ptr_q];
  assign m_valid  = (fill_q != 2'd0);

endmodule

// File: tb/tb_ram_sp_18_stream_reader.sv
// Directed bench for ram_sp_18_stream_reader with a RAM model and an expected-word queue.
// Honours RAM_SP_RD_WRAP_EN for the boundary case.
module tb_ram_sp_18_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] length;
  logic        busy, done, err;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [17:0] ram_dout;
  logic [17:0] m_data;
  logic        m_valid;
  logic        m_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int n_pop = 0;
  int bp_base = 0;
  logic bp_chk = 1'b0;
  logic [17:0] exp_q [$];
  logic [17:0] mem [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read data follows the registered address one cycle after issue.
  assign ram_dout = mem[ram_addr];

  ram_sp_18_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  function automatic logic [17:0] ref_word(input int a);
    logic [17:0] w;
    w = 18'(a % 1024);
    return w ^ 18'h2AAAA;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input int a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_word(a + i));
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_done"}, 32'(done), 0);
    check({pfx, "_err"}, 32'(err), 0);
    check({pfx, "_ram_addr"}, 32'(ram_addr), 0);
    check({pfx, "_ram_we"}, 32'(ram_we), 0);
    check({pfx, "_m_valid"}, 32'(m_valid), 0);
    check({pfx, "_m_data"}, 32'(m_data), 0);
  endtask

  // Start is accepted at the returned edge; t0 is the cycle count after it.
  task automatic do_start(input int a, input int n);
    @(posedge clk);
    #1 start = 1'b1; start_addr = 10'(a); length = 11'(n);
    @(posedge clk);
    #1 start = 1'b0; t0 = cyc;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output logic got, output int lat,
                           output logic busy_at);
    got = 1'b0; lat = -1; busy_at = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; lat = cyc - t0; busy_at = busy;
        break;
      end
    end
    check("done_seen", 32'(got), 1);
  endtask

  // Scoreboard: every transfer pops and compares the oldest expected word.
  always @(negedge clk) begin
    logic [17:0] want;
    int ahead;
    if (!rst && m_valid && m_ready) begin
      if (bp_chk) begin
        ahead = int'(ram_addr) - bp_base + 1 - n_pop;
        check("bp_read_ahead_le2", 32'(ahead <= 2), 1);
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 18'bx;
      check("stream_data", 32'(m_data), 32'(want));
      n_pop++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, busy_at, seen;
    int lat, pops0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 1024; i++) mem[i] = 18'(i) ^ 18'h2AAAA;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic burst
    push_exp(5, 4);
    do_start(5, 4);
    check("basic_busy_k0", 32'(busy), 1);
    check("basic_valid_k0", 32'(m_valid), 0);
    @(negedge clk);
    check("basic_addr_k1", 32'(ram_addr), 5);
    check("basic_valid_k1", 32'(m_valid), 0);
    check("basic_we", 32'(ram_we), 0);
    @(negedge clk);
    check("basic_valid_k2", 32'(m_valid), 1);
    wait_done(20, got, lat, busy_at);
    check("basic_done_lat", 32'(lat), 6);
    check("basic_busy_at_done", 32'(busy_at), 0);
    check("basic_q_empty", 32'(exp_q.size()), 0);

    // Backpressure with 1,0,0,1 pattern
    n_pop = 0; bp_base = 100; bp_chk = 1'b1;
    push_exp(100, 8);
    do_start(100, 8);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1 m_ready = pat[i % 4];
      @(negedge clk);
      if (done) got = 1'b1;
    end
    bp_chk = 1'b0;
    check("bp_done_seen", 32'(got), 1);
    check("bp_count", 32'(n_pop), 8);
    check("bp_q_empty", 32'(exp_q.size()), 0);

    // Held backpressure: only two reads outstanding
    @(posedge clk);
    #1 m_ready = 1'b0;
    push_exp(200, 6);
    do_start(200, 6);
    repeat (8) @(negedge clk);
    check("hold_addr", 32'(ram_addr), 201);
    check("hold_valid", 32'(m_valid), 1);
    check("hold_busy", 32'(busy), 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(30, got, lat, busy_at);
    check("hold_q_empty", 32'(exp_q.size()), 0);

    // Boundary start 1020, length 8
`ifdef RAM_SP_RD_WRAP_EN
    push_exp(1020, 8);
    do_start(1020, 8);
    wait_done(40, got, lat, busy_at);
    check("wrap_done_lat", 32'(lat), 10);
    check("wrap_q_empty", 32'(exp_q.size()), 0);
`else
    do_start(1020, 8);
    check("bound_err_k0", 32'(err), 1);
    check("bound_busy_k0", 32'(busy), 0);
    @(negedge clk);
    check("bound_err_k1", 32'(err), 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | m_valid | busy;
    end
    check("bound_no_activity", 32'(seen), 0);
`endif

    // Zero length
    do_start(7, 0);
    check("zero_done_k0", 32'(done), 1);
    check("zero_busy_k0", 32'(busy), 0);
    @(negedge clk);
    check("zero_done_k1", 32'(done), 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | m_valid;
    end
    check("zero_no_valid", 32'(seen), 0);

    // Full length
    pops0 = n_pop;
    push_exp(0, 1024);
    do_start(0, 1024);
    wait_done(1100, got, lat, busy_at);
    check("full_count", 32'(n_pop - pops0), 1024);
    check("full_done_lat", 32'(lat), 1026);
    check("full_q_empty", 32'(exp_q.size()), 0);

    // Reset mid-burst after three words
    pops0 = n_pop;
    push_exp(300, 10);
    do_start(300, 10);
    for (int i = 0; i < 30 && (n_pop - pops0) < 3; i++) @(negedge clk);
    check("mid_words_before_rst", 32'(n_pop - pops0), 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done | m_valid | busy;
    end
    check("post_rst_idle", 32'(seen), 0);

    // Restart, with an ignored start while busy
    push_exp(0, 2);
    do_start(0, 2);
    @(posedge clk);
    #1 start = 1'b1; start_addr = 10'd500; length = 11'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20, got, lat, busy_at);
    check("restart_done_lat", 32'(lat), 4);
    check("restart_q_empty", 32'(exp_q.size()), 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | m_valid | busy | done;
    end
    check("restart_ignored_start", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
